tile_fill_sched: RTL and testbench

- Frame-level sequencer for the tile cache filler.
- Walks a frame stored in external RAM in raster order of tiles (left to right, then top to bottom).
- For each tile: issues one go pulse with tile position and clipped size to the filler, waits for the fill to complete, then hands the tile to the downstream consumer and waits for its release.
- Sits between the frame-control registers and the fill/consume pair. It never touches the wishbone bus itself.

---
 rtl/tile_fill_sched.sv | 170 +++++++++++++++++
 tb/tb_tile_fill_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_fill_sched.sv
// Frame-level tile sequencer: walks the frame in raster tile order, launching fills and handing tiles to the consumer.
// Optional abort input is enabled by defining TILE_FILL_SCHED_ABORT_EN.
module tile_fill_sched #(
    parameter int IM_WIDTH    = 640,
    parameter int IM_HEIGHT   = 480,
    parameter int ADDR_SIZE_W = 5,
    parameter int ADDR_SIZE_H = 5,
    parameter int TILE_W      = 16,
    parameter int TILE_H      = 16
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   start,
`ifdef TILE_FILL_SCHED_ABORT_EN
    input  logic                   abort,
`endif
    input  logic [31:0]            im_addr_I,
    output logic                   go,
    output logic [9:0]             pixel_c_O,
    output logic [9:0]             pixel_l_O,
    output logic [ADDR_SIZE_W:0]   cache_w_O,
    output logic [ADDR_SIZE_H:0]   cache_h_O,
    output logic [31:0]            im_addr_O,
    input  logic                   fill_done,
    output logic                   tile_valid,
    input  logic                   tile_done,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_FILL    = 3'd2,
        S_PROCESS = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [10:0]          IMW11 = 11'(IM_WIDTH);
    localparam logic [10:0]          IMH11 = 11'(IM_HEIGHT);
    localparam logic [10:0]          TW11  = 11'(TILE_W);
    localparam logic [10:0]          TH11  = 11'(TILE_H);
    localparam logic [ADDR_SIZE_W:0] TW    = (ADDR_SIZE_W+1)'(TILE_W);
    localparam logic [ADDR_SIZE_H:0] TH    = (ADDR_SIZE_H+1)'(TILE_H);

    state_t                 state_q, state_d;
    logic [9:0]             col_q, col_d;
    logic [9:0]             line_q, line_d;
    logic [ADDR_SIZE_W:0]   w_q, w_d;
    logic [ADDR_SIZE_H:0]   h_q, h_d;
    logic [31:0]            addr_q, addr_d;
    logic                   upd;
    logic [10:0]            col_nx, line_nx;
    logic                   abort_now;
    logic                   abort_q, abort_d;

    // 11-bit remainder cannot wrap because col/line always stay below the image size
    function automatic logic [ADDR_SIZE_W:0] clip_w(input logic [9:0] c);
        logic [10:0] rem;
        rem = IMW11 - {1'b0, c};
        if (rem < TW11) return rem[ADDR_SIZE_W:0];
        return TW;
    endfunction

    function automatic logic [ADDR_SIZE_H:0] clip_h(input logic [9:0] l);
        logic [10:0] rem;
        rem = IMH11 - {1'b0, l};
        if (rem < TH11) return rem[ADDR_SIZE_H:0];
        return TH;
    endfunction

`ifdef TILE_FILL_SCHED_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    assign col_nx  = {1'b0, col_q} + TW11;
    assign line_nx = {1'b0, line_q} + TH11;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        addr_d  = addr_q;
        abort_d = abort_q;
        upd     = 1'b0;
        w_d     = w_q;
        h_d     = h_q;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    state_d = S_LAUNCH;
                    addr_d  = im_addr_I;
                    col_d   = '0;
                    line_d  = '0;
                    upd     = 1'b1;
                end
            end
            S_LAUNCH: begin
                if (abort_now) abort_d = 1'b1;
                state_d = S_FILL;
            end
            S_FILL: begin
                if (abort_now) abort_d = 1'b1;
                // the filler cannot be stopped, so an abort only takes effect once it reports done
                if (fill_done) state_d = (abort_q || abort_now) ? S_IDLE : S_PROCESS;
            end
            S_PROCESS: begin
                if (abort_now)      state_d = S_IDLE;
                else if (tile_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (abort_now) begin
                    state_d = S_IDLE;
                end else if (col_nx < IMW11) begin
                    col_d   = col_nx[9:0];
                    upd     = 1'b1;
                    state_d = S_LAUNCH;
                end else if (line_nx < IMH11) begin
                    col_d   = '0;
                    line_d  = line_nx[9:0];
                    upd     = 1'b1;
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (upd) begin
            w_d = clip_w(col_d);
            h_d = clip_h(line_d);
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            addr_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            w_q     <= w_d;
            h_q     <= h_d;
            addr_q  <= addr_d;
            abort_q <= abort_d;
        end
    end

    assign go         = (state_q == S_LAUNCH);
    assign tile_valid = (state_q == S_PROCESS);
    assign frame_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign pixel_c_O  = col_q;
    assign pixel_l_O  = line_q;
    assign cache_w_O  = w_q;
    assign cache_h_O  = h_q;
    assign im_addr_O  = addr_q;

endmodule

// File: tb/tb_tile_fill_sched.sv
// Directed bench: a 40x20 instance (clipping, latency, spurious inputs, reset) and a 32x32 instance (exact fit).
module tb_tile_fill_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRST, start, fill_done, tile_done, sel;
    logic [31:0] addr_in;
`ifdef TILE_FILL_SCHED_ABORT_EN
    logic        abort;
`endif

    logic        a_go, a_tv, a_busy, a_fd, b_go, b_tv, b_busy, b_fd;
    logic [9:0]  a_pc, a_pl, b_pc, b_pl;
    logic [5:0]  a_w, a_h, b_w, b_h;
    logic [31:0] a_addr, b_addr;

    tile_fill_sched #(.IM_WIDTH(40), .IM_HEIGHT(20), .ADDR_SIZE_W(5), .ADDR_SIZE_H(5),
                      .TILE_W(16), .TILE_H(16)) dut_a (
        .clk(clk), .nRST(nRST), .start(start & ~sel),
`ifdef TILE_FILL_SCHED_ABORT_EN
        .abort(abort & ~sel),
`endif
        .im_addr_I(addr_in), .go(a_go), .pixel_c_O(a_pc), .pixel_l_O(a_pl),
        .cache_w_O(a_w), .cache_h_O(a_h), .im_addr_O(a_addr),
        .fill_done(fill_done & ~sel), .tile_valid(a_tv), .tile_done(tile_done & ~sel),
        .busy(a_busy), .frame_done(a_fd));

    tile_fill_sched #(.IM_WIDTH(32), .IM_HEIGHT(32), .ADDR_SIZE_W(5), .ADDR_SIZE_H(5),
                      .TILE_W(16), .TILE_H(16)) dut_b (
        .clk(clk), .nRST(nRST), .start(start & sel),
`ifdef TILE_FILL_SCHED_ABORT_EN
        .abort(abort & sel),
`endif
        .im_addr_I(addr_in), .go(b_go), .pixel_c_O(b_pc), .pixel_l_O(b_pl),
        .cache_w_O(b_w), .cache_h_O(b_h), .im_addr_O(b_addr),
        .fill_done(fill_done & sel), .tile_valid(b_tv), .tile_done(tile_done & sel),
        .busy(b_busy), .frame_done(b_fd));

    logic        o_go, o_tv, o_busy, o_fd;
    logic [9:0]  o_pc, o_pl;
    logic [5:0]  o_w, o_h;
    logic [31:0] o_addr;

    always_comb begin
        o_go   = sel ? b_go   : a_go;
        o_tv   = sel ? b_tv   : a_tv;
        o_busy = sel ? b_busy : a_busy;
        o_fd   = sel ? b_fd   : a_fd;
        o_pc   = sel ? b_pc   : a_pc;
        o_pl   = sel ? b_pl   : a_pl;
        o_w    = sel ? b_w    : a_w;
        o_h    = sel ? b_h    : a_h;
        o_addr = sel ? b_addr : a_addr;
    end

    int go_cnt = 0, fd_cnt = 0, tv_cnt = 0;
    logic tv_prev = 1'b0;
    always @(negedge clk) begin
        if (o_go) go_cnt <= go_cnt + 1;
        if (o_fd) fd_cnt <= fd_cnt + 1;
        if (o_tv && !tv_prev) tv_cnt <= tv_cnt + 1;
        tv_prev <= o_tv;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [31:0] a);
        addr_in = a;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Entered in the cycle where go is expected; returns in the cycle after NEXT.
    task automatic do_tile(input int c, input int l, input int w, input int h,
                           input int fd, input int td, input bit spur, input bit last,
                           input logic [31:0] a);
        check("go_pulse", {31'b0, o_go}, 32'd1);
        check("pixel_c", {22'b0, o_pc}, c);
        check("pixel_l", {22'b0, o_pl}, l);
        check("cache_w", {26'b0, o_w}, w);
        check("cache_h", {26'b0, o_h}, h);
        check("im_addr", o_addr, a);
        for (int i = 1; i <= fd; i++) begin
            tick();
            if (i == 1) begin
                check("go_one_cycle", {31'b0, o_go}, 32'd0);
                if (spur) begin
                    tile_done = 1'b1;
                    start     = 1'b1;
                end
            end
            if (i == 2) begin
                tile_done = 1'b0;
                start     = 1'b0;
            end
            if (i == fd) begin
                check("tv_in_fill", {31'b0, o_tv}, 32'd0);
                fill_done = 1'b1;
            end
        end
        tick();
        fill_done = 1'b0;
        check("tv_after_fill", {31'b0, o_tv}, 32'd1);
        for (int j = 1; j <= td; j++) begin
            tick();
            if (j == 1 && spur) fill_done = 1'b1;
            if (j == 2) fill_done = 1'b0;
            if (j == td) begin
                check("tv_held", {31'b0, o_tv}, 32'd1);
                check("pixel_c_stable", {22'b0, o_pc}, c);
                tile_done = 1'b1;
            end
        end
        tick();
        tile_done = 1'b0;
        check("tv_in_next", {31'b0, o_tv}, 32'd0);
        check("busy_in_next", {31'b0, o_busy}, 32'd1);
        tick();
        if (last) begin
            check("frame_done", {31'b0, o_fd}, 32'd1);
            check("no_go_at_done", {31'b0, o_go}, 32'd0);
        end
    endtask

    task automatic check_idle_after_frame();
        tick();
        check("busy_idle", {31'b0, o_busy}, 32'd0);
        check("frame_done_pulse", {31'b0, o_fd}, 32'd0);
    endtask

    initial begin
        int g0, f0, v0;
        nRST = 1'b0; start = 1'b0; fill_done = 1'b0; tile_done = 1'b0; sel = 1'b0;
        addr_in = 32'h0;
`ifdef TILE_FILL_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        check("rst_go", {31'b0, o_go}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_tv", {31'b0, o_tv}, 32'd0);
        check("rst_addr", o_addr, 32'd0);
        tick();
        nRST = 1'b1;
        tick();
        tick();
        check("idle_busy", {31'b0, o_busy}, 32'd0);

        // Frame 1 on 40x20; first tile uses the 9/4 latency case
        g0 = go_cnt; f0 = fd_cnt; v0 = tv_cnt;
        begin_frame(32'h1000_0000);
        do_tile(0,  0,  16, 16, 9, 4, 1'b0, 1'b0, 32'h1000_0000);
        do_tile(16, 0,  16, 16, 3, 2, 1'b1, 1'b0, 32'h1000_0000);
        do_tile(32, 0,  8,  16, 3, 2, 1'b0, 1'b0, 32'h1000_0000);
        do_tile(0,  16, 16, 4,  3, 2, 1'b1, 1'b0, 32'h1000_0000);
        do_tile(16, 16, 16, 4,  3, 2, 1'b0, 1'b0, 32'h1000_0000);
        do_tile(32, 16, 8,  4,  3, 2, 1'b0, 1'b1, 32'h1000_0000);
        check_idle_after_frame();
        tick();
        check("go_count_f1", go_cnt - g0, 6);
        check("fd_count_f1", fd_cnt - f0, 1);
        check("tv_count_f1", tv_cnt - v0, 6);

        // Reset in FILL of tile 2, then restart from (0,0)
        begin_frame(32'h2000_0040);
        do_tile(0, 0, 16, 16, 3, 2, 1'b0, 1'b0, 32'h2000_0040);
        tick();
        tick();
        nRST = 1'b0;
        #1;
        check("arst_go", {31'b0, o_go}, 32'd0);
        check("arst_busy", {31'b0, o_busy}, 32'd0);
        check("arst_tv", {31'b0, o_tv}, 32'd0);
        check("arst_fd", {31'b0, o_fd}, 32'd0);
        check("arst_pc", {22'b0, o_pc}, 32'd0);
        check("arst_pl", {22'b0, o_pl}, 32'd0);
        check("arst_w", {26'b0, o_w}, 32'd0);
        check("arst_h", {26'b0, o_h}, 32'd0);
        check("arst_addr", o_addr, 32'd0);
        tick();
        nRST = 1'b1;
        tick();
        begin_frame(32'h3000_0000);
        do_tile(0,  0,  16, 16, 3, 2, 1'b0, 1'b0, 32'h3000_0000);
        do_tile(16, 0,  16, 16, 3, 2, 1'b0, 1'b0, 32'h3000_0000);
        do_tile(32, 0,  8,  16, 3, 2, 1'b0, 1'b0, 32'h3000_0000);
        do_tile(0,  16, 16, 4,  3, 2, 1'b0, 1'b0, 32'h3000_0000);
        do_tile(16, 16, 16, 4,  3, 2, 1'b0, 1'b0, 32'h3000_0000);
        do_tile(32, 16, 8,  4,  3, 2, 1'b0, 1'b1, 32'h3000_0000);
        check_idle_after_frame();

        // Exact fit on 32x32
        sel = 1'b1;
        tick();
        tick();
        g0 = go_cnt; f0 = fd_cnt;
        begin_frame(32'h4000_0000);
        do_tile(0,  0,  16, 16, 3, 2, 1'b0, 1'b0, 32'h4000_0000);
        do_tile(16, 0,  16, 16, 3, 2, 1'b0, 1'b0, 32'h4000_0000);
        do_tile(0,  16, 16, 16, 3, 2, 1'b0, 1'b0, 32'h4000_0000);
        do_tile(16, 16, 16, 16, 3, 2, 1'b0, 1'b1, 32'h4000_0000);
        check_idle_after_frame();
        tick();
        check("go_count_fit", go_cnt - g0, 4);
        check("fd_count_fit", fd_cnt - f0, 1);
        sel = 1'b0;
        tick();

`ifdef TILE_FILL_SCHED_ABORT_EN
        f0 = fd_cnt; v0 = tv_cnt;
        begin_frame(32'h5000_0000);
        do_tile(0,  0, 16, 16, 3, 2, 1'b0, 1'b0, 32'h5000_0000);
        do_tile(16, 0, 16, 16, 3, 2, 1'b0, 1'b0, 32'h5000_0000);
        check("ab_go", {31'b0, o_go}, 32'd1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("ab_wait_fill", {31'b0, o_busy}, 32'd1);
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        check("ab_idle", {31'b0, o_busy}, 32'd0);
        check("ab_no_tv", {31'b0, o_tv}, 32'd0);
        tick();
        tick();
        check("ab_no_fd", fd_cnt - f0, 0);
        check("ab_tv_count", tv_cnt - v0, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
